exe_div: RTL
============

EXE_DIV -- requirements
Module: exe_div

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 EXE_DivStart  input  1  EXE-stage request for OP_DIV/OP_DIVU; sampled on the rising edge.
REQ-005 EXE_DivSigned  input  1  1 = OP_DIV (signed), 0 = OP_DIVU (unsigned); sampled with EXE_DivStart.
REQ-006 EXE_DivA  input  32  dividend (forwarded rs value); sampled with EXE_DivStart.
REQ-007 EXE_DivB  input  32  divisor (forwarded rt value); sampled with EXE_DivStart.
REQ-008 Div_Cancel  input  1  flush or exception kill of the in-flight divide.
REQ-009 Div_Stall  output  1  combinational; holds PC, IF_ID and ID_EXE while the divide is pending.
REQ-010 Div_Done  output  1  registered; one-cycle pulse when the results are valid.
REQ-011 Div_Quotient  output  32  registered quotient, written to LO.
REQ-012 Div_Remainder  output  32  registered remainder, written to HI.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-014 In IDLE or DONE, EXE_DivStart=1 and Div_Cancel=0 SHALL latch the operands, EXE_DivSigned, and the sign flags (dividend sign, quotient sign), clear the 5-bit iteration counter, and move the FSM to CALC.
REQ-015 In CALC, EXE_DivStart SHALL be ignored and the latched operands SHALL NOT change.
REQ-016 The divider SHALL be radix-2 restoring on the magnitudes. When signed, each magnitude is the two's-complement absolute value of the operand; when unsigned, it is the raw operand.
REQ-017 Each CALC iteration SHALL shift the 33-bit partial remainder left by one bit, bringing in the next dividend MSB. The divisor magnitude is then subtracted. If the result is non-negative, the remainder is updated and quotient bit 1 is shifted in. Otherwise the remainder is kept and quotient bit 0 is shifted in.
REQ-018 CALC SHALL perform exactly 32 iterations. The edge that completes iteration 32 (counter = 31) SHALL move the FSM to DONE.
REQ-019 On entry to DONE, Div_Quotient and Div_Remainder SHALL be loaded as follows.
  - Signed: the quotient is negated if the operand signs differ; the remainder takes the sign of the dividend.
  - Unsigned: the raw results are loaded.
REQ-020 Div_Done SHALL be 1 only in DONE. DONE SHALL last one cycle and then return to IDLE, or go to CALC if a new start is accepted per REQ-014.
REQ-021 Div_Stall SHALL equal (EXE_DivStart & ~Div_Cancel & state∈{IDLE,DONE}) | (state==CALC).
REQ-022 Latency: a start sampled at edge E0 SHALL give Div_Done=1 in the cycle after edge E32. Div_Stall SHALL be high from the start cycle through the cycle before Div_Done.
REQ-023 Div_Quotient and Div_Remainder SHALL hold their values from DONE until the next DONE entry.
REQ-024 Divisor 0 SHALL use the normal latency and give quotient 0xFFFFFFFF and remainder = EXE_DivA, for both signed and unsigned, with no sign fix-up.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0x00000000 (wrap-around, no exception).
REQ-026 Div_Cancel=1 in any state SHALL force IDLE at the next edge with no Div_Done pulse and the result registers unchanged.
REQ-027 Div_Cancel SHALL take priority over a simultaneous EXE_DivStart.

Reset
REQ-028 rst=1 SHALL force IDLE, counter 0, Div_Done 0, Div_Quotient 0, Div_Remainder 0, and all internal operand and sign registers 0.
REQ-029 rst=1 SHALL override EXE_DivStart and Div_Cancel, and SHALL abort CALC without producing a Div_Done pulse.
REQ-030 After rst is released, Div_Stall SHALL be 0 until EXE_DivStart is asserted.

Verification
REQ-031 Unsigned 100/7 started at E0 -> Div_Done=1 only in the cycle after E32; Quotient=0x0000000E, Remainder=0x00000002; Div_Stall high for exactly 33 cycles.
REQ-032 Signed -7/2 (0xFFFFFFF9/0x00000002) -> Quotient=0xFFFFFFFD, Remainder=0xFFFFFFFF. Signed 7/-2 -> Quotient=0xFFFFFFFD, Remainder=0x00000001.
REQ-033 Signed 0x80000000/0xFFFFFFFF -> Quotient=0x80000000, Remainder=0. Unsigned 0x12345678/0 -> Quotient=0xFFFFFFFF, Remainder=0x12345678.
REQ-034 Div_Cancel pulsed at iteration 10 -> IDLE next cycle, no Div_Done, previous results unchanged. Start and Cancel in the same cycle -> stays IDLE, Div_Stall=0.
REQ-035 Back-to-back: second start asserted in the DONE cycle -> accepted; second Div_Done 33 cycles later. rst asserted mid-CALC -> all outputs 0 next cycle, no Div_Done.

Source files
------------

// File: rtl/exe_div.sv
// ============================================================================
// Module   : exe_div
// Purpose  : EXE-stage radix-2 restoring divider for OP_DIV / OP_DIVU,
//            32 iterations, registered quotient (LO) and remainder (HI).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exe_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXE_DivStart,
    input  logic        EXE_DivSigned,
    input  logic [31:0] EXE_DivA,
    input  logic [31:0] EXE_DivB,
    input  logic        Div_Cancel,
    output logic        Div_Stall,
    output logic        Div_Done,
    output logic [31:0] Div_Quotient,
    output logic [31:0] Div_Remainder
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] C_LAST_ITER = 5'd31;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_a;          // raw dividend, needed for the divide-by-zero remainder
    logic [31:0] r_b;
    logic        r_signed;
    logic        r_sign_a;
    logic        r_sign_q;
    logic [31:0] r_dvs;        // divisor magnitude
    logic [31:0] r_quo;        // dividend magnitude shifts out MSB-first, quotient shifts in
    logic [31:0] r_rem;
    logic        r_done;
    logic [31:0] r_q_out;
    logic [31:0] r_r_out;

    logic        w_idle_like;
    logic        w_accept;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_q_final;
    logic [31:0] w_r_final;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept    = EXE_DivStart && !Div_Cancel && w_idle_like;
    assign Div_Stall   = w_accept || (r_state == S_CALC);

    assign w_mag_a = (EXE_DivSigned && EXE_DivA[31]) ? (32'd0 - EXE_DivA) : EXE_DivA;
    assign w_mag_b = (EXE_DivSigned && EXE_DivB[31]) ? (32'd0 - EXE_DivB) : EXE_DivB;

    // The remainder stays below the divisor, so the 32-bit difference is exact.
    assign w_shift    = {r_rem, r_quo[31]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_sub      = w_shift[31:0] - r_dvs;
    assign w_rem_next = w_ge ? w_sub : w_shift[31:0];
    assign w_quo_next = {r_quo[30:0], w_ge};

    // Divide-by-zero bypasses the sign fix-up and returns the raw dividend.
    always_comb begin
        w_q_final = w_quo_next;
        w_r_final = w_rem_next;
        if (r_b == 32'd0) begin
            w_q_final = 32'hFFFF_FFFF;
            w_r_final = r_a;
        end else if (r_signed) begin
            if (r_sign_q) w_q_final = 32'd0 - w_quo_next;
            if (r_sign_a) w_r_final = 32'd0 - w_rem_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_signed <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_q <= 1'b0;
            r_dvs    <= 32'd0;
            r_quo    <= 32'd0;
            r_rem    <= 32'd0;
            r_done   <= 1'b0;
            r_q_out  <= 32'd0;
            r_r_out  <= 32'd0;
        end else if (Div_Cancel) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (EXE_DivStart) begin
                        r_state  <= S_CALC;
                        r_cnt    <= 5'd0;
                        r_a      <= EXE_DivA;
                        r_b      <= EXE_DivB;
                        r_signed <= EXE_DivSigned;
                        r_sign_a <= EXE_DivA[31];
                        r_sign_q <= EXE_DivA[31] ^ EXE_DivB[31];
                        r_dvs    <= w_mag_b;
                        r_quo    <= w_mag_a;
                        r_rem    <= 32'd0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == C_LAST_ITER) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_q_out <= w_q_final;
                        r_r_out <= w_r_final;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign Div_Done      = r_done;
    assign Div_Quotient  = r_q_out;
    assign Div_Remainder = r_r_out;

endmodule

`default_nettype wire
